// File: rtl/dual_slope_ctrl.sv
// dual_slope_ctrl: N-digit dual-slope A/D conversion controller.
// Runs the auto-zero / integrate / de-integrate cycle. It counts the
// de-integrate time in BCD and latches a signed, range-flagged reading.
// Optional digit-scan readout is built only when the macro DS_SCAN_EN is defined.
// Without it, DS and Q are tied to zero.

module dual_slope_ctrl #(
    parameter int NDIG      = 3,
    parameter int AZ_CYCLES = 16,
    parameter int SCAN_DIV  = 4
) (
    input  logic              CP0,
    input  logic              R8,
    input  logic              D,
    input  logic              DU,
    output logic              AZ,
    output logic              INTEG,
    output logic              DEINT,
    output logic              EOC,
    output logic [4*NDIG-1:0] BCD,
    output logic              HALF,
    output logic              POL,
    output logic              OR,
    output logic              UR,
    output logic [NDIG:0]     DS,
    output logic [3:0]        Q
);

    localparam int TimerW = (AZ_CYCLES > 1) ? $clog2(AZ_CYCLES) : 1;
    localparam int CntW   = 4*NDIG + 1;

    // Reject parameter values the sequencing cannot honour
    if ((AZ_CYCLES < 2) || (SCAN_DIV < 1) || (NDIG < 1)) begin : gParamCheck
        $error("dual_slope_ctrl: illegal parameter value");
    end

    typedef enum logic [1:0] {
        S_AUTOZERO,
        S_INTEGRATE,
        S_DEINTEGRATE
    } convStateT;

    convStateT           state, stateNext;
    logic [TimerW-1:0]   azTimer, azTimerNext;
    logic [CntW-1:0]     cnt, cntNext;
    logic                polReg, polNext;
    logic                dMeta, dSync;
    logic                allNine;
    logic                loadResult;
    logic                overNext;
    logic                eocNext;

    // BCD increment of {half, digits}; each digit wraps 9->0 with carry
    function automatic logic [CntW-1:0] bcdInc(input logic [CntW-1:0] value);
        logic [CntW-1:0] res;
        logic            carry;
        res   = value;
        carry = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (carry) begin
                if (value[4*i +: 4] == 4'd9) begin
                    res[4*i +: 4] = 4'd0;
                end else begin
                    res[4*i +: 4] = value[4*i +: 4] + 4'd1;
                    carry         = 1'b0;
                end
            end
        end
        if (carry) begin
            res[CntW-1] = ~value[CntW-1];
        end
        return res;
    endfunction

    // Two-flop synchronizer for the asynchronous comparator; idles high
    always_ff @(posedge CP0) begin
        if (R8) begin
            dMeta <= 1'b1;
            dSync <= 1'b1;
        end else begin
            dMeta <= D;
            dSync <= dMeta;
        end
    end

    // Next-state logic: phase sequencing, BCD count and end-of-conversion decision
    always_comb begin
        stateNext   = state;
        azTimerNext = azTimer;
        cntNext     = cnt;
        polNext     = polReg;
        eocNext     = 1'b0;
        loadResult  = 1'b0;
        overNext    = 1'b0;
        allNine     = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (cnt[4*i +: 4] != 4'd9) begin
                allNine = 1'b0;
            end
        end
        case (state)
            S_AUTOZERO: begin
                if (azTimer == TimerW'(AZ_CYCLES - 1)) begin
                    stateNext   = S_INTEGRATE;
                    azTimerNext = '0;
                    cntNext     = '0;
                end else begin
                    azTimerNext = azTimer + TimerW'(1);
                end
            end
            S_INTEGRATE: begin
                if (!cnt[CntW-1] && allNine) begin
                    stateNext = S_DEINTEGRATE;
                    cntNext   = '0;
                    polNext   = dSync;
                end else begin
                    cntNext = bcdInc(cnt);
                end
            end
            S_DEINTEGRATE: begin
                if (!dSync || (cnt[CntW-1] && allNine)) begin
                    stateNext   = S_AUTOZERO;
                    azTimerNext = '0;
                    cntNext     = '0;
                    eocNext     = 1'b1;
                    loadResult  = DU;
                    overNext    = dSync;
                end else begin
                    cntNext = bcdInc(cnt);
                end
            end
            default: begin
                stateNext   = S_AUTOZERO;
                azTimerNext = '0;
                cntNext     = '0;
            end
        endcase
    end

    // State register plus registered, glitch-free switch controls and EOC pulse
    always_ff @(posedge CP0) begin
        if (R8) begin
            state   <= S_AUTOZERO;
            azTimer <= '0;
            cnt     <= '0;
            polReg  <= 1'b0;
            AZ      <= 1'b1;
            INTEG   <= 1'b0;
            DEINT   <= 1'b0;
            EOC     <= 1'b0;
        end else begin
            state   <= stateNext;
            azTimer <= azTimerNext;
            cnt     <= cntNext;
            polReg  <= polNext;
            AZ      <= (stateNext == S_AUTOZERO);
            INTEG   <= (stateNext == S_INTEGRATE);
            DEINT   <= (stateNext == S_DEINTEGRATE);
            EOC     <= eocNext;
        end
    end

    // Result latch: loads on the edge that raises EOC, only when display update is enabled
    always_ff @(posedge CP0) begin
        if (R8) begin
            BCD  <= '0;
            HALF <= 1'b0;
            POL  <= 1'b0;
            OR   <= 1'b0;
            UR   <= 1'b0;
        end else if (loadResult) begin
            BCD  <= cnt[4*NDIG-1:0];
            HALF <= cnt[CntW-1];
            POL  <= polReg;
            OR   <= overNext;
            UR   <= !cnt[CntW-1] && (cnt[4*NDIG-1 -: 4] == 4'd0);
        end
    end

`ifdef DS_SCAN_EN
    localparam int IdxW = $clog2(NDIG + 1);
    localparam int DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic            scanActive;
    logic [DivW-1:0] scanDiv;
    logic [IdxW-1:0] scanIdx;

    // Free-running digit scan: starts on the half-digit slot after reset release
    always_ff @(posedge CP0) begin
        if (R8) begin
            scanActive <= 1'b0;
            scanDiv    <= '0;
            scanIdx    <= IdxW'(NDIG);
        end else if (!scanActive) begin
            scanActive <= 1'b1;
            scanDiv    <= '0;
            scanIdx    <= IdxW'(NDIG);
        end else if (scanDiv == DivW'(SCAN_DIV - 1)) begin
            scanDiv <= '0;
            if (scanIdx == '0) begin
                scanIdx <= IdxW'(NDIG);
            end else begin
                scanIdx <= scanIdx - IdxW'(1);
            end
        end else begin
            scanDiv <= scanDiv + DivW'(1);
        end
    end

    // Strobe decode and digit mux; combinational so a result load shows at once
    always_comb begin
        DS = '0;
        Q  = 4'd0;
        if (scanActive) begin
            for (int i = 0; i <= NDIG; i++) begin
                if (scanIdx == IdxW'(i)) begin
                    DS[i] = 1'b1;
                    if (i == NDIG) begin
                        Q = {OR, UR, POL, HALF};
                    end else begin
                        Q = BCD[4*i +: 4];
                    end
                end
            end
        end
    end
`else
    // Scan readout not built: strobes and data held low
    always_comb begin
        DS = '0;
        Q  = 4'd0;
    end
`endif

endmodule
